// File: rtl/sync_ram_bytelane_if.sv
// Request/completion bus between the load/store unit (master) and the byte-lane data RAM (slave).
// req side: cs/we/address/data_input/byte_en; completion side: ready/ack/data_output/parity_err.
interface sync_ram_bytelane_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                    cs;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   data_input;
  logic [DATA_WIDTH/8-1:0] byte_en;
  logic                    ready;
  logic                    ack;
  logic [DATA_WIDTH-1:0]   data_output;
  logic                    parity_err;

  modport master (
    output cs, we, address, data_input, byte_en,
    input  ready, ack, data_output, parity_err
  );

  modport slave (
    input  cs, we, address, data_input, byte_en,
    output ready, ack, data_output, parity_err
  );
endinterface

// File: rtl/sync_ram_bytelane.sv
// Single-port byte-lane data RAM; access WAIT_STATES+1 edges after accept, ack one cycle later.
// cs is accepted only while ready=1 and never queued; RAM_PARITY_EN adds per-lane even parity.
module sync_ram_bytelane #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  sync_ram_bytelane_if.slave bus
);
  localparam int                  LANES   = DATA_WIDTH / 8;
  localparam int                  IDX_W   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [3:0]          WAIT_L  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            ready_q;
  logic            ack_q;

  logic                  req_we_q,   req_we_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_wdat_q, req_wdat_d;
  logic [LANES-1:0]      req_be_q,   req_be_d;
  logic [DATA_WIDTH-1:0] dout_q,     dout_d;

  logic [DATA_WIDTH-1:0] mem_q [0:RAM_DEPTH-1];

  logic             accept;
  logic             access;
  logic             in_range;
  logic [IDX_W-1:0] idx;

  assign accept   = (state_q == S_IDLE) && bus.cs;
  assign access   = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign in_range = {1'b0, req_addr_q} < DEPTH_L;
  assign idx      = req_addr_q[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.cs) begin
          state_q <= S_WAIT;
          cnt_q   <= WAIT_L;
          ready_q <= 1'b0;
        end
        S_WAIT: if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          state_q <= S_ACK;
          ack_q   <= 1'b1;
        end
        S_ACK: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    req_we_d   = req_we_q;
    req_addr_d = req_addr_q;
    req_wdat_d = req_wdat_q;
    req_be_d   = req_be_q;
    dout_d     = dout_q;
    if (accept) begin
      req_we_d   = bus.we;
      req_addr_d = bus.address;
      req_wdat_d = bus.data_input;
      req_be_d   = bus.byte_en;
    end
    // Out-of-range reads return zero rather than aliasing onto a real word.
    if (access && !req_we_q) begin
      dout_d = in_range ? mem_q[idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_we_q   <= 1'b0;
      req_addr_q <= '0;
      req_wdat_q <= '0;
      req_be_q   <= '0;
      dout_q     <= '0;
    end else begin
      req_we_q   <= req_we_d;
      req_addr_q <= req_addr_d;
      req_wdat_q <= req_wdat_d;
      req_be_q   <= req_be_d;
      dout_q     <= dout_d;
    end
  end

`ifdef RAM_PARITY_EN
  logic [LANES-1:0] par_q [0:RAM_DEPTH-1];
  logic             rd_perr;
  logic             perr_q, perr_d;

  always_comb begin
    rd_perr = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if ((^mem_q[idx][8*i +: 8]) != par_q[idx][i]) rd_perr = 1'b1;
    end
  end

  always_comb begin
    perr_d = perr_q;
    if (access) perr_d = !req_we_q && in_range && rd_perr;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) perr_q <= 1'b0;
    else          perr_q <= perr_d;
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  // Storage is never reset; a write is suppressed on the edge where reset is asserted.
  always_ff @(posedge clk) begin
    if (reset_n && access && req_we_q && in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (req_be_q[i]) begin
          mem_q[idx][8*i +: 8] <= req_wdat_q[8*i +: 8];
`ifdef RAM_PARITY_EN
          par_q[idx][i] <= ^req_wdat_q[8*i +: 8];
`endif
        end
      end
    end
  end

  assign bus.ready       = ready_q;
  assign bus.ack         = ack_q;
  assign bus.data_output = dout_q;
endmodule

// File: tb/tb_sync_ram_bytelane.sv
// Directed bench: u_a has no wait states and 512 words; u_b has 3 wait states and full depth.
module tb_sync_ram_bytelane;
  logic clk;
  logic rst_a_n, rst_b_n;
  int   n_vec = 0;
  int   n_err = 0;

  sync_ram_bytelane_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus_a ();
  sync_ram_bytelane_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus_b ();

  sync_ram_bytelane #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RAM_DEPTH(512), .WAIT_STATES(0)) u_a (
    .clk(clk), .reset_n(rst_a_n), .bus(bus_a.slave));
  sync_ram_bytelane #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RAM_DEPTH(1024), .WAIT_STATES(3)) u_b (
    .clk(clk), .reset_n(rst_b_n), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on u_a with exact cycle-by-cycle handshake checks.
  task automatic req_a(input logic w, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd, output logic pe);
    @(negedge clk);
    bus_a.cs = 1'b1; bus_a.we = w; bus_a.address = a; bus_a.data_input = d; bus_a.byte_en = be;
    @(posedge clk);
    #1 bus_a.cs = 1'b0;
    @(negedge clk);
    chk("a_ready_wait", {31'd0, bus_a.ready}, 32'd0);
    chk("a_ack_wait", {31'd0, bus_a.ack}, 32'd0);
    @(negedge clk);
    chk("a_ready_ack", {31'd0, bus_a.ready}, 32'd0);
    chk("a_ack_pulse", {31'd0, bus_a.ack}, 32'd1);
    rd = bus_a.data_output;
    pe = bus_a.parity_err;
    @(negedge clk);
    chk("a_ready_back", {31'd0, bus_a.ready}, 32'd1);
    chk("a_ack_drop", {31'd0, bus_a.ack}, 32'd0);
  endtask

  // One request on u_b with a bounded wait for ack.
  task automatic req_b(input logic w, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd);
    int lat;
    @(negedge clk);
    bus_b.cs = 1'b1; bus_b.we = w; bus_b.address = a; bus_b.data_input = d; bus_b.byte_en = be;
    @(posedge clk);
    #1 bus_b.cs = 1'b0;
    lat = 0;
    rd  = 32'hxxxx_xxxx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus_b.ack === 1'b1) begin
        lat = k;
        rd  = bus_b.data_output;
        break;
      end
    end
    chk("b_ack_latency", lat, 32'd5);
    @(negedge clk);
    chk("b_ready_after", {31'd0, bus_b.ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        pe;
    int          n_ack;

    bus_a.cs = 1'b0; bus_a.we = 1'b0; bus_a.address = '0; bus_a.data_input = '0; bus_a.byte_en = '0;
    bus_b.cs = 1'b0; bus_b.we = 1'b0; bus_b.address = '0; bus_b.data_input = '0; bus_b.byte_en = '0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", {31'd0, bus_a.ready}, 32'd1);
    chk("rst_a_ack", {31'd0, bus_a.ack}, 32'd0);
    chk("rst_a_dout", bus_a.data_output, 32'd0);
    chk("rst_a_perr", {31'd0, bus_a.parity_err}, 32'd0);
    chk("rst_b_ready", {31'd0, bus_b.ready}, 32'd1);
    chk("rst_b_ack", {31'd0, bus_b.ack}, 32'd0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Full-word write/read, then lane-masked writes.
    req_a(1'b1, 10'h005, 32'hDEADBEEF, 4'hF, rd, pe);
    req_a(1'b0, 10'h005, 32'h0, 4'h0, rd, pe);
    chk("full_word_rd", rd, 32'hDEADBEEF);
    chk("full_word_perr", {31'd0, pe}, 32'd0);
    req_a(1'b1, 10'h005, 32'h11223344, 4'b0101, rd, pe);
    req_a(1'b0, 10'h005, 32'h0, 4'h0, rd, pe);
    chk("lane_rd", rd, 32'hDE22BE44);
    req_a(1'b1, 10'h005, 32'hFFFFFFFF, 4'h0, rd, pe);
    chk("write_keeps_dout", rd, 32'hDE22BE44);
    chk("write_perr_zero", {31'd0, pe}, 32'd0);
    req_a(1'b0, 10'h005, 32'h0, 4'h0, rd, pe);
    chk("be0_rd", rd, 32'hDE22BE44);

    // Out-of-range access with no aliasing onto word 0.
    req_a(1'b1, 10'h000, 32'h12345678, 4'hF, rd, pe);
    req_a(1'b1, 10'h200, 32'hAABBCCDD, 4'hF, rd, pe);
    req_a(1'b0, 10'h200, 32'h0, 4'h0, rd, pe);
    chk("oor_rd", rd, 32'h0);
    chk("oor_perr", {31'd0, pe}, 32'd0);
    req_a(1'b0, 10'h000, 32'h0, 4'h0, rd, pe);
    chk("no_alias_rd", rd, 32'h12345678);

`ifdef RAM_PARITY_EN
    req_a(1'b1, 10'h003, 32'h000000FF, 4'hF, rd, pe);
    @(negedge clk);
    u_a.par_q[3][0] = ~u_a.par_q[3][0];
    req_a(1'b0, 10'h003, 32'h0, 4'h0, rd, pe);
    chk("par_bad_rd", rd, 32'h000000FF);
    chk("par_bad_err", {31'd0, pe}, 32'd1);
    req_a(1'b1, 10'h003, 32'h000000FF, 4'hF, rd, pe);
    req_a(1'b0, 10'h003, 32'h0, 4'h0, rd, pe);
    chk("par_ok_err", {31'd0, pe}, 32'd0);
`endif

    // Three wait states: latency, and cs held high is not queued.
    req_b(1'b1, 10'h020, 32'h0000A5A5, 4'hF, rd);
    req_b(1'b1, 10'h010, 32'h00000000, 4'hF, rd);
    @(negedge clk);
    bus_b.cs = 1'b1; bus_b.we = 1'b0; bus_b.address = 10'h020;
    @(posedge clk);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk($sformatf("hold_ack_%0d", k), {31'd0, bus_b.ack}, (k == 5 || k == 11) ? 32'd1 : 32'd0);
      chk($sformatf("hold_rdy_%0d", k), {31'd0, bus_b.ready}, (k == 6) ? 32'd1 : 32'd0);
      if (k == 5) chk("hold_rd", bus_b.data_output, 32'h0000A5A5);
    end
    bus_b.cs = 1'b0;
    @(negedge clk);
    chk("hold_idle_rdy", {31'd0, bus_b.ready}, 32'd1);

    // Reset while a write is still waiting.
    @(negedge clk);
    bus_b.cs = 1'b1; bus_b.we = 1'b1; bus_b.address = 10'h010;
    bus_b.data_input = 32'hCAFEF00D; bus_b.byte_en = 4'hF;
    @(posedge clk);
    #1 bus_b.cs = 1'b0;
    @(negedge clk);
    rst_b_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, bus_b.ready}, 32'd1);
    chk("midrst_ack", {31'd0, bus_b.ack}, 32'd0);
    chk("midrst_dout", bus_b.data_output, 32'd0);
    chk("midrst_perr", {31'd0, bus_b.parity_err}, 32'd0);
    rst_b_n = 1'b1;
    n_ack = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus_b.ack === 1'b1) n_ack++;
    end
    chk("midrst_no_ack", n_ack, 32'd0);
    req_b(1'b0, 10'h010, 32'h0, 4'h0, rd);
    chk("midrst_rd", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
